// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: prescales the system clock into 2 Hz / 1 Hz strobes
// and drives count enables, clear and blink for the seconds/minutes BCD counters.
module stopwatch_ctrl #(
  parameter int unsigned HALF_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause_p,
  input  logic clr_p,
  input  logic adj,
  input  logic sel,
  input  logic sec_carry,
  output logic sec_en,
  output logic min_en,
  output logic cnt_clr,
  output logic blink,
  output logic running
);

  localparam int unsigned PC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  state_t          state;
  logic            run_f;
  logic [PC_W-1:0] pc;
  logic            phase;
  logic            t2;
  logic            t1;

  assign t2 = (pc == PC_W'(HALF_DIV - 1));
  assign t1 = t2 && phase;

  // Prescaler, mode FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PAUSED;
      run_f   <= 1'b0;
      pc      <= '0;
      phase   <= 1'b0;
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      cnt_clr <= 1'b0;
      blink   <= 1'b0;
      running <= 1'b0;
    end else begin
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      cnt_clr <= 1'b0;
      if (clr_p) begin
        // Clear restarts the timebase and drops any strobe landing in this cycle
        cnt_clr <= 1'b1;
        pc      <= '0;
        phase   <= 1'b0;
        run_f   <= 1'b0;
        blink   <= 1'b0;
        running <= 1'b0;
        state   <= adj ? ADJUST : PAUSED;
      end else begin
        pc <= t2 ? '0 : pc + PC_W'(1);
        if (t2) phase <= ~phase;
        case (state)
          PAUSED: begin
            if (adj) begin
              state <= ADJUST;
              if (pause_p) run_f <= ~run_f;
            end else if (pause_p) begin
              state   <= RUN;
              run_f   <= 1'b1;
              running <= 1'b1;
            end
          end
          RUN: begin
            // Strobe uses RUN rules even when leaving RUN this cycle
            if (t1) begin
              sec_en <= 1'b1;
              min_en <= sec_carry;
            end
            if (adj) begin
              state   <= ADJUST;
              running <= 1'b0;
              if (pause_p) run_f <= ~run_f;
            end else if (pause_p) begin
              state   <= PAUSED;
              run_f   <= 1'b0;
              running <= 1'b0;
            end
          end
          ADJUST: begin
            if (t2) begin
              sec_en <= sel;
              min_en <= ~sel;
              blink  <= ~blink;
            end
            if (pause_p) run_f <= ~run_f;
            if (!adj) begin
              blink <= 1'b0;
              if (run_f ^ pause_p) begin
                state   <= RUN;
                running <= 1'b1;
              end else begin
                state   <= PAUSED;
              end
            end
          end
          default: begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with HALF_DIV = 4.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst, pause_p, clr_p, adj, sel, sec_carry;
  logic sec_en, min_en, cnt_clr, blink, running;

  int n_cmp = 0;
  int n_err = 0;
  int n     = 0;

  stopwatch_ctrl #(.HALF_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pause_p   (pause_p),
    .clr_p     (clr_p),
    .adj       (adj),
    .sel       (sel),
    .sec_carry (sec_carry),
    .sec_en    (sec_en),
    .min_en    (min_en),
    .cnt_clr   (cnt_clr),
    .blink     (blink),
    .running   (running)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle to the falling edge for sampling
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, n, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sec_en"},  sec_en,  1'b0);
    check({tag, "_min_en"},  min_en,  1'b0);
    check({tag, "_cnt_clr"}, cnt_clr, 1'b0);
    check({tag, "_blink"},   blink,   1'b0);
    check({tag, "_running"}, running, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pause_p = 1'b0; clr_p = 1'b0; adj = 1'b0; sel = 1'b0; sec_carry = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    check_idle("reset");

    // Edge numbering restarts at reset release: pc == n mod 4 after edge n
    rst = 1'b0; n = 0;
    pause_p = 1'b1; cyc(); pause_p = 1'b0;
    check("run_start", running, 1'b1);
    while (n < 24) begin
      cyc();
      check("run_sec_en", sec_en, (n % 8) == 0);
      check("run_min_en", min_en, 1'b0);
    end

    sec_carry = 1'b1;
    while (n < 40) begin
      cyc();
      check("carry_sec_en", sec_en, (n % 8) == 0);
      check("carry_min_en", min_en, (n % 8) == 0);
    end
    sec_carry = 1'b0;

    pause_p = 1'b1; cyc(); pause_p = 1'b0;
    check("pause_running", running, 1'b0);
    while (n < 56) begin
      cyc();
      check("paused_sec_en", sec_en, 1'b0);
      check("paused_min_en", min_en, 1'b0);
    end

    // ADJUST entered on edge 57; strobes on multiples of 4
    adj = 1'b1; sel = 1'b1;
    while (n < 72) begin
      cyc();
      check("adj_s_sec_en", sec_en, (n % 4) == 0);
      check("adj_s_min_en", min_en, 1'b0);
      check("adj_s_blink", blink, ((n / 4) % 2) == 1);
      check("adj_s_running", running, 1'b0);
    end
    sel = 1'b0;
    while (n < 88) begin
      cyc();
      check("adj_m_min_en", min_en, (n % 4) == 0);
      check("adj_m_sec_en", sec_en, 1'b0);
      check("adj_m_blink", blink, ((n / 4) % 2) == 1);
    end
    adj = 1'b0; cyc();
    check("adj_exit_blink", blink, 1'b0);
    check("adj_exit_running", running, 1'b0);

    // pause_p together with adj rising: ADJUST, run_f toggles to 1
    adj = 1'b1; pause_p = 1'b1; cyc();
    check("same_cycle_running", running, 1'b0);
    adj = 1'b0; pause_p = 1'b0; cyc();
    check("same_cycle_exit_run", running, 1'b1);

    // From RUN into ADJUST, toggle run_f twice, exit back to RUN
    adj = 1'b1; cyc();
    check("adj2_running", running, 1'b0);
    check("adj2_sec_en", sec_en, 1'b0);
    pause_p = 1'b1; cyc(); cyc();
    pause_p = 1'b0; adj = 1'b0; cyc();
    check("adj2_exit_run", running, 1'b1);
    cyc();
    check("resume_sec_en", sec_en, 1'b1);
    check("resume_min_en", min_en, 1'b0);

    // Clear on edge 97 restarts the timebase
    clr_p = 1'b1; cyc(); clr_p = 1'b0;
    check("clr_cnt_clr", cnt_clr, 1'b1);
    check("clr_running", running, 1'b0);
    check("clr_sec_en", sec_en, 1'b0);
    pause_p = 1'b1; cyc(); pause_p = 1'b0;
    check("clr_cnt_clr_once", cnt_clr, 1'b0);
    check("clr_restart_run", running, 1'b1);
    while (n < 104) begin
      cyc();
      check("clr_quiet_sec_en", sec_en, 1'b0);
    end
    cyc();
    check("clr_first_sec_en", sec_en, 1'b1);
    while (n < 112) cyc();

    // Reset in the t1 cycle (edge 113): no trailing enable
    rst = 1'b1; cyc();
    check_idle("rst_strobe");
    cyc();
    check_idle("rst_hold");
    rst = 1'b0; cyc();
    check("post_rst_running", running, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the two-digit BCD counter pair (seconds, minutes) of the lab3b stopwatch. It divides the system clock into 1 Hz and 2 Hz timing strobes, runs a RUN/PAUSE/ADJUST state machine from debounced button pulses and switch levels, and drives the counters' count-enable and clear inputs plus a display blink flag. It sits between the debouncer and the `adv_counter` instances; it has no datapath of its own.

## Interface
- `HALF_DIV`, default 50_000_000: system clock cycles per 2 Hz strobe period; 1 Hz strobe period is 2×`HALF_DIV`; minimum value 2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pause_p` input 1: single-cycle pulse, toggles run/pause.
- `clr_p` input 1: single-cycle pulse, clears time to 00:00.
- `adj` input 1: level, 1 selects adjust mode.
- `sel` input 1: level, adjust target: 0 = minutes, 1 = seconds.
- `sec_carry` input 1: from seconds counter, high while seconds counter holds 59.
- `sec_en` output 1: registered one-cycle count enable to seconds counter.
- `min_en` output 1: registered one-cycle count enable to minutes counter.
- `cnt_clr` output 1: registered one-cycle synchronous clear to both counters.
- `blink` output 1: display blank flag for selected digit pair in ADJUST.
- `running` output 1: high in RUN.

## Operation
- Prescaler: counter `pc` 0..`HALF_DIV`-1, wraps to 0; `t2` = (`pc` == `HALF_DIV`-1); `phase` bit toggles on every `t2`; `t1` = `t2` && `phase` == 1. Prescaler free-runs in all states.
- Run flag `run_f`: remembers whether time advances when not adjusting.
- States: PAUSED, RUN, ADJUST.
- PAUSED: `adj`=1 -> ADJUST; else `pause_p` -> RUN (`run_f`=1).
- RUN: `adj`=1 -> ADJUST; else `pause_p` -> PAUSED (`run_f`=0). On `t1`: `sec_en`=1 next cycle; `min_en`=1 next cycle iff `sec_carry`=1 in the `t1` cycle.
- ADJUST: `pause_p` toggles `run_f`, state stays. On `t2`: `sel`=1 -> `sec_en` pulse only; `sel`=0 -> `min_en` pulse only; no carry propagation. `blink` toggles on each `t2`. `adj`=0 -> RUN if `run_f`, else PAUSED; `blink` forced 0 on exit.
- `clr_p`: `cnt_clr`=1 next cycle; `pc`, `phase` zeroed; `sec_en`/`min_en` suppressed that cycle; state -> PAUSED, `run_f`=0, unless `adj`=1, which stays/goes ADJUST with `run_f`=0.
- Priority in any cycle: `rst` > `clr_p` > `adj` transition > `pause_p` > strobe enables.
- `running` = (state == RUN).

## Timing
- Reset values: state PAUSED, `run_f`=0, `pc`=0, `phase`=0, `sec_en`=0, `min_en`=0, `cnt_clr`=0, `blink`=0, `running`=0.
- All outputs registered; enable pulses occur exactly one cycle after the strobe cycle and are one cycle wide.
- First `t2` occurs `HALF_DIV` cycles after reset release or `clr_p`; first `t1` occurs 2×`HALF_DIV` cycles after.
- State change takes effect at the next edge; a strobe coinciding with a transition cycle is evaluated with the old state's rules, except that `clr_p` suppresses the strobe.
- `pause_p` and `adj` edge in the same cycle: `adj` wins, and `pause_p` is applied to `run_f` as in ADJUST.
- 59→00 wrap: `min_en` and `sec_en` pulse in the same cycle; minutes wrap at 59 is the counter's responsibility, not the controller's.
- `rst` mid-pulse: outputs go to reset values at the next edge, with no trailing enable.

## Test plan
- Use `HALF_DIV`=4 throughout. Reset, then `pause_p` -> `running`=1; `sec_en` pulses once every 8 cycles, the first 8 cycles after reset release; `min_en` stays 0 while `sec_carry`=0.
- RUN with `sec_carry` held 1 -> every `sec_en` pulse is accompanied by a same-cycle `min_en` pulse; second `pause_p` -> no further enables, `running`=0.
- `adj`=1, `sel`=1 -> `sec_en` every 4 cycles, `min_en`=0, `blink` toggles every 4 cycles. Switch to `sel`=0 -> `min_en` every 4 cycles, `sec_en`=0. Drop `adj` -> `blink`=0, return to the prior RUN/PAUSED state.
- RUN, `clr_p` -> `cnt_clr`=1 for exactly 1 cycle next edge; state PAUSED; no enable for 8+ cycles; after `pause_p`, the first `sec_en` comes 8 cycles after `clr_p`.
- In ADJUST, `pause_p` then `adj`=0 -> RUN; `pause_p` and `adj` rising in the same cycle -> ADJUST with `run_f` toggled.
- Assert `rst` in the strobe cycle of RUN -> no `sec_en` next cycle; all outputs are 0 and state is PAUSED.
